// File: rtl/el2_dec_trigger_csr.sv
// Debug trigger CSR bank (tselect/tdata1/tdata2 x4) driving the trigger packets and collecting match hits.
// Optional build macro TRIGGER_CHAIN_EN enables chaining of trigger pairs 0/1 and 2/3.
package el2_dec_trigger_csr_pkg;
    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } el2_trigger_pkt_t;
endpackage

module el2_dec_trigger_csr
    import el2_dec_trigger_csr_pkg::*;
#(
    parameter int          NUM_TRIG  = 4,
    parameter logic [11:0] TSEL_ADDR = 12'h7A0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  dbg_mode,
    input  logic                                  csr_wen,
    input  logic [11:0]                           csr_waddr,
    input  logic [31:0]                           csr_wdata,
    input  logic                                  csr_ren,
    input  logic [11:0]                           csr_raddr,
    output logic [31:0]                           csr_rdata,
    output logic                                  csr_rvalid,
    input  logic [NUM_TRIG-1:0]                   lsu_trigger_match_m,
    input  logic [NUM_TRIG-1:0]                   ifu_trigger_match,
    output el2_trigger_pkt_t [NUM_TRIG-1:0]       trigger_pkt_any,
    output logic [NUM_TRIG-1:0]                   trigger_fire,
    output logic                                  trigger_halt,
    output logic                                  trigger_brkpt
);
    localparam logic [11:0] TDATA1_ADDR = TSEL_ADDR + 12'd1;
    localparam logic [11:0] TDATA2_ADDR = TSEL_ADDR + 12'd2;

    logic [1:0]          tselect;
    logic [NUM_TRIG-1:0] dmode, hit, sel, action, chain, match, m, execute, store, load;
    logic [31:0]         tdata2 [NUM_TRIG];
    logic [31:0]         tdata1_val [NUM_TRIG];
    logic [31:0]         rd_mux;
    logic [NUM_TRIG-1:0] raw, q;
    logic                locked, wr_tsel, wr_td1, wr_td2, chain_wdata;
    logic                unused_wdata;

    // A trigger owned by the debugger cannot be touched from normal mode.
    assign locked  = dmode[tselect] & ~dbg_mode;
    assign wr_tsel = csr_wen && (csr_waddr == TSEL_ADDR);
    assign wr_td1  = csr_wen && (csr_waddr == TDATA1_ADDR) && !locked;
    assign wr_td2  = csr_wen && (csr_waddr == TDATA2_ADDR) && !locked;

`ifdef TRIGGER_CHAIN_EN
    assign chain_wdata = csr_wdata[11] & ~tselect[0];
`else
    assign chain_wdata = 1'b0;
`endif

    assign unused_wdata = ^{csr_wdata[31:28], csr_wdata[26:21], csr_wdata[18:13],
                            csr_wdata[11], csr_wdata[10:8], csr_wdata[5:3]};

    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            tdata1_val[i] = {4'd2, dmode[i], 6'h1F, hit[i], sel[i], 1'b0, 5'b0,
                             action[i], chain[i], 3'b0, match[i], m[i], 3'b0,
                             execute[i], store[i], load[i]};
        end
    end

    always_comb begin
        rd_mux = '0;
        case (csr_raddr)
            TSEL_ADDR:   rd_mux = {30'b0, tselect};
            TDATA1_ADDR: rd_mux = tdata1_val[tselect];
            TDATA2_ADDR: rd_mux = tdata2[tselect];
            default:     rd_mux = '0;
        endcase
    end

    always_comb begin
        raw = lsu_trigger_match_m | (ifu_trigger_match & execute);
        q   = raw;
`ifdef TRIGGER_CHAIN_EN
        for (int e = 0; e < NUM_TRIG; e += 2) begin
            if (chain[e]) begin
                q[e]   = raw[e] & raw[e+1];
                q[e+1] = raw[e] & raw[e+1];
            end
        end
`endif
    end

    // Packets are combinational so matchers see a CSR write on the same edge it lands.
    always_comb begin
        trigger_pkt_any = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            trigger_pkt_any[i].select  = sel[i];
            trigger_pkt_any[i].match   = match[i];
            trigger_pkt_any[i].store   = store[i];
            trigger_pkt_any[i].load    = load[i];
            trigger_pkt_any[i].execute = execute[i];
            trigger_pkt_any[i].m       = m[i] & ~(dmode[i] & dbg_mode);
            trigger_pkt_any[i].tdata2  = tdata2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tselect       <= '0;
            dmode         <= '0;
            hit           <= '0;
            sel           <= '0;
            action        <= '0;
            chain         <= '0;
            match         <= '0;
            m             <= '0;
            execute       <= '0;
            store         <= '0;
            load          <= '0;
            for (int i = 0; i < NUM_TRIG; i++) tdata2[i] <= '0;
            trigger_fire  <= '0;
            trigger_halt  <= 1'b0;
            trigger_brkpt <= 1'b0;
            csr_rdata     <= '0;
            csr_rvalid    <= 1'b0;
        end else begin
            if (wr_tsel) tselect <= csr_wdata[1:0];
            for (int i = 0; i < NUM_TRIG; i++) begin
                // A software write to tdata1 overrides the hardware hit update for that trigger.
                if (wr_td1 && (tselect == 2'(i))) begin
                    dmode[i]   <= csr_wdata[27] & dbg_mode;
                    hit[i]     <= csr_wdata[20];
                    sel[i]     <= csr_wdata[19];
                    action[i]  <= csr_wdata[12];
                    chain[i]   <= chain_wdata;
                    match[i]   <= csr_wdata[7];
                    m[i]       <= csr_wdata[6];
                    execute[i] <= csr_wdata[2];
                    store[i]   <= csr_wdata[1];
                    load[i]    <= csr_wdata[0];
                end else if (trigger_fire[i]) begin
                    hit[i] <= 1'b1;
                end
                if (wr_td2 && (tselect == 2'(i))) tdata2[i] <= csr_wdata;
            end
            trigger_fire  <= q;
            trigger_halt  <= |(q & action);
            trigger_brkpt <= |(q & ~action);
            csr_rvalid    <= csr_ren;
            csr_rdata     <= csr_ren ? rd_mux : 32'h0;
        end
    end
endmodule
